alu_op_scheduler: RTL and testbench
===================================

Name: alu_op_scheduler

Overview:
- Shares the single ALU + 16-bit output register between two requesters (ports 0/1) using round-robin arbitration.
- Sequences each accepted operation: drives ALU operands/opcode, waits the op's latency, pulses the output register load, then returns the registered result with a valid/ready handshake.
- Sits between the requester logic and the ALU/output-register datapath. Only one operation is in flight at a time.

Parameters:
- MULDIV_LAT, 4, ALU cycles for multiply/divide opcodes (range 1..15)
- MUL_OP, 4'b1000, opcode of multiply
- DIV_OP, 4'b1001, opcode of divide

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a  in  8  requester 0 operand A
- req0_b  in  8  requester 0 operand B
- req0_op  in  4  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- alu_a  out  8  registered ALU operand A
- alu_b  out  8  registered ALU operand B
- alu_op  out  4  registered ALU opcode
- out_load  out  1  load strobe to the output register
- out_data  in  16  current output register content
- resp_valid  out  1  result available
- resp_id  out  1  requester the result belongs to
- resp_data  out  16  result
- resp_ready  in  1  consumer accepts the result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; rr pointer=0; alu_a/alu_b/alu_op=0; out_load=0; resp_valid=0; resp_id=0; resp_data=0; lat counter=0. Reset mid-operation aborts the op; no response is produced.
- States: IDLE, EXEC, LOAD, RESP.
- IDLE, grant selection (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant requester rr.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready high per cycle; ready never asserts without the corresponding valid.
- Accept (reqN_valid && reqN_ready at a rising edge):
  - Latch a/b/op into alu_a/alu_b/alu_op; resp_id<=N; rr<=~N.
  - counter <= MULDIV_LAT if op==MUL_OP or op==DIV_OP, else 1.
  - Go to EXEC. All other opcodes are single-cycle; no illegal-op error.
- EXEC: decrement counter each cycle. When counter==1, go to LOAD. EXEC therefore lasts exactly the op latency.
- LOAD: out_load=1 for exactly this one cycle; go to RESP. The output register captures the ALU result at the end of the LOAD cycle.
- RESP:
  - On entry, resp_data is registered from out_data (the value the output register holds after the LOAD edge).
  - resp_valid=1 and resp_id/resp_data are held stable until resp_ready is sampled high.
  - On that edge: resp_valid<=0, go to IDLE.
- Operand stability: alu_a/alu_b/alu_op hold their values from accept until the next accept.
- Latency, simple op with resp_ready tied high: accept at edge E; out_load high during cycle E+2; resp_valid high during cycle E+3; IDLE again in cycle E+4. A multiply/divide adds MULDIV_LAT-1 cycles.
- Back-to-back: no new request is accepted before returning to IDLE. Requests held valid in RESP stay pending; their ready stays 0.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,... starting from 0 after reset.
- busy=1 in EXEC, LOAD and RESP.

Test Plan:
- Single add: req0 a=8'h12, b=8'h34, op=4'h0, resp_ready=1 -> out_load is a one-cycle pulse 2 cycles after accept; resp_valid 1 cycle later with resp_id=0 and resp_data equal to the model output-register value (16'h0046).
- Multiply latency: req1 a=8'hFF, b=8'hFF, op=MUL_OP, MULDIV_LAT=4 -> out_load 5 cycles after accept; resp_data=16'hFE01; resp_id=1.
- Contention: both valid continuously for 4 ops -> grant order 0,1,0,1; never both ready in one cycle.
- Response backpressure: resp_ready=0 for 6 cycles in RESP -> resp_valid/resp_data stable; no new accept; busy=1; accept resumes the cycle after IDLE.
- Reset mid-EXEC: assert reset during a multiply -> all outputs return to 0 immediately; no out_load pulse; the next request is served normally with rr=0.
- Idle sanity: no valids for 20 cycles -> busy=0, out_load=0, resp_valid=0.

Source files
------------

// File: rtl/alu_op_scheduler.sv
// Round-robin scheduler sharing one ALU and its 16-bit output register between two requesters.
// Sequences one operation at a time: operand drive, latency wait, output load, result handshake.
module alu_op_scheduler #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter logic [3:0]  MUL_OP     = 4'b1000,
  parameter logic [3:0]  DIV_OP     = 4'b1001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [3:0]  req1_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  output logic        out_load,
  input  logic [15:0] out_data,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [15:0] resp_data,
  input  logic        resp_ready,
  output logic        busy
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;
  localparam int unsigned RW  = 16;
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {IDLE, EXEC, LOAD, RESP} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_load_q, out_load_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_id_q, resp_id_d;
  logic [RW-1:0]   resp_data_q, resp_data_d;
  logic            resp_cap_q, resp_cap_d;

  logic            any_valid;
  logic            grant_id;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic [OPW-1:0]  sel_op;
  logic            sel_muldiv;

  // Round-robin grant: rr only breaks ties when both requesters are valid.
  assign any_valid  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid & req1_valid) ? rr_q : req1_valid;
  assign req0_ready = (state_q == IDLE) & req0_valid & ~grant_id;
  assign req1_ready = (state_q == IDLE) & req1_valid & grant_id;

  assign sel_a      = grant_id ? req1_a  : req0_a;
  assign sel_b      = grant_id ? req1_b  : req0_b;
  assign sel_op     = grant_id ? req1_op : req0_op;
  assign sel_muldiv = (sel_op == MUL_OP) || (sel_op == DIV_OP);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    cnt_d        = cnt_q;
    out_load_d   = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_cap_d   = resp_cap_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          alu_a_d   = sel_a;
          alu_b_d   = sel_b;
          alu_op_d  = sel_op;
          resp_id_d = grant_id;
          rr_d      = ~grant_id;
          cnt_d     = sel_muldiv ? CW'(MULDIV_LAT) : CW'(1);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_load_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        resp_valid_d = 1'b1;
        resp_cap_d   = 1'b0;
        state_d      = RESP;
      end
      RESP: begin
        if (!resp_cap_q) begin
          resp_data_d = out_data;
          resp_cap_d  = 1'b1;
        end
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      cnt_q        <= '0;
      out_load_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_cap_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      cnt_q        <= cnt_d;
      out_load_q   <= out_load_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_cap_q   <= resp_cap_d;
    end
  end

  // The output register only updates at the LOAD edge, so in the first RESP cycle
  // its content is forwarded directly; it is held in resp_data_q from then on.
  assign resp_data  = (resp_valid_q && !resp_cap_q) ? out_data : resp_data_q;

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_load   = out_load_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler with a behavioural ALU and output register.
module tb_alu_op_scheduler;

  localparam logic [3:0] MUL_C = 4'b1000;
  localparam logic [3:0] DIV_C = 4'b1001;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        out_load;
  logic [15:0] outreg_q = 16'h0;
  logic        resp_valid, resp_id, resp_ready, busy;
  logic [15:0] resp_data;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_op_scheduler #(.MULDIV_LAT(4), .MUL_OP(MUL_C), .DIV_OP(DIV_C)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_load(out_load), .out_data(outreg_q),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready),
    .busy(busy)
  );

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'h0:    return 16'(a) + 16'(b);
      4'h1:    return 16'(a) - 16'(b);
      4'h2:    return 16'(a & b);
      4'h3:    return 16'(a | b);
      MUL_C:   return 16'(a) * 16'(b);
      DIV_C:   return (b == 8'h0) ? 16'hFFFF : 16'(a / b);
      default: return 16'(a ^ b);
    endcase
  endfunction

  // Datapath stand-in: the output register captures the ALU result on out_load.
  always @(posedge clk) if (out_load) outreg_q <= alu_model(alu_a, alu_b, alu_op);

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: ready rules every cycle, response popped against the scoreboard on handshake.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      check("ready_rule", 32'((req0_ready & req1_ready) | (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid)), 32'd0);
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_id", 32'(resp_id), 32'(e.id));
          check("resp_data", 32'(resp_data), 32'(e.data));
        end
      end
    end
  end

  task automatic issue(input bit port, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input bit push, input logic [15:0] expd);
    bit got;
    got = 1'b0;
    if (port == 1'b0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    else              begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    for (int i = 0; i < 100; i++) begin
      #1;
      if ((port == 1'b0) ? req0_ready : req1_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("accepted", 32'(got), 32'd1);
    if (got) begin
      @(posedge clk);
      if (push) sb.push_back('{id: port, data: expd});
      @(negedge clk);
    end
    if (port == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin @(negedge clk); n++; end
    check("return_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   order [4];
    int   nacc, guard, loads;
    reset = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({busy, out_load, resp_valid, resp_id, resp_data}), 32'd0);
    check("reset_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single add from requester 0.
    issue(1'b0, 8'h12, 8'h34, 4'h0, 1'b1, 16'h0046);
    check("add_load_early", 32'(out_load), 32'd0);
    @(negedge clk);
    check("add_load_pulse", 32'(out_load), 32'd1);
    check("add_operands", 32'({alu_a, alu_b, alu_op}), 32'({8'h12, 8'h34, 4'h0}));
    @(negedge clk);
    check("add_load_width", 32'(out_load), 32'd0);
    check("add_resp", 32'({resp_valid, resp_id, resp_data}), 32'({1'b1, 1'b0, 16'h0046}));
    @(negedge clk);
    check("add_idle", 32'(busy), 32'd0);

    // Multiply latency from requester 1.
    issue(1'b1, 8'hFF, 8'hFF, MUL_C, 1'b1, 16'hFE01);
    for (int i = 0; i < 4; i++) begin
      check("mul_no_load_yet", 32'(out_load), 32'd0);
      @(negedge clk);
    end
    check("mul_load", 32'(out_load), 32'd1);
    @(negedge clk);
    check("mul_resp", 32'({resp_valid, resp_id, resp_data}), 32'({1'b1, 1'b1, 16'hFE01}));
    wait_idle(10);

    // Contention: both valid continuously, grants must alternate 0,1,0,1.
    req0_a = 8'h03; req0_b = 8'h04; req0_op = 4'h0;
    req1_a = 8'h0A; req1_b = 8'h03; req1_op = MUL_C;
    sb.push_back('{id: 1'b0, data: 16'h0007});
    sb.push_back('{id: 1'b1, data: 16'h001E});
    sb.push_back('{id: 1'b0, data: 16'h0007});
    sb.push_back('{id: 1'b1, data: 16'h001E});
    req0_valid = 1'b1; req1_valid = 1'b1;
    nacc = 0; guard = 0;
    while (nacc < 4 && guard < 200) begin
      #1;
      if (req0_ready || req1_ready) begin order[nacc] = req1_ready; nacc++; end
      @(negedge clk);
      guard++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("contention_count", 32'(nacc), 32'd4);
    for (int i = 0; i < 4; i++) check("grant_order", 32'(order[i]), 32'(i % 2));
    wait_idle(40);

    // Response backpressure with a pending request from requester 1.
    resp_ready = 1'b0;
    issue(1'b0, 8'h5C, 8'h3A, 4'h2, 1'b1, 16'h0018);
    req1_a = 8'h01; req1_b = 8'h01; req1_op = 4'h0; req1_valid = 1'b1;
    guard = 0;
    while (!resp_valid && guard < 20) begin @(negedge clk); guard++; end
    check("bp_resp_valid", 32'(resp_valid), 32'd1);
    repeat (6) begin
      #1;
      check("bp_hold", 32'({resp_valid, busy, req1_ready, resp_data}), 32'({1'b1, 1'b1, 1'b0, 16'h0018}));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_resume_ready", 32'({busy, req1_ready}), 32'({1'b0, 1'b1}));
    issue(1'b1, 8'h01, 8'h01, 4'h0, 1'b1, 16'h0002);
    wait_idle(10);

    // Reset during a multiply: aborted, no load, rr back to 0.
    issue(1'b0, 8'h02, 8'h03, MUL_C, 1'b0, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_async_ctl", 32'({busy, out_load, resp_valid, resp_id, resp_data}), 32'd0);
    check("rst_async_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    loads = 0;
    repeat (8) begin
      if (out_load || resp_valid) loads++;
      @(negedge clk);
    end
    check("rst_no_load", 32'(loads), 32'd0);
    req0_a = 8'h20; req0_b = 8'h22; req0_op = 4'h0; req0_valid = 1'b1;
    req1_a = 8'h07; req1_b = 8'h07; req1_op = 4'h0; req1_valid = 1'b1;
    #1;
    check("rst_rr_grant", 32'({req0_ready, req1_ready}), 32'({1'b1, 1'b0}));
    issue(1'b0, 8'h20, 8'h22, 4'h0, 1'b1, 16'h0042);
    req1_valid = 1'b0;
    wait_idle(10);
    @(negedge clk);

    // Idle sanity.
    repeat (20) begin
      check("idle_quiet", 32'({busy, out_load, resp_valid}), 32'd0);
      @(negedge clk);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
